exec_mask_scan: RTL and testbench
=================================

Name: exec_mask_scan

Overview:
- Inverse direction of the lane-count-to-mask generator: takes a 64-lane exec/thermometer mask and emits the index of every set lane, lowest first, one per handshake.
- Also reports total active-lane count and whether the mask is a contiguous thermometer mask (bits 0..k set), returning k.
- Sits between issue/exec-mask state and per-lane sequencing logic (LSU address walk, per-lane writeback).

Parameters:
- LANES, 64, mask width; must equal 2**IDX_W.
- IDX_W, 6, lane index width.

Ports:
- clk  input  1  clock, all state rising-edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the mask in flight.
- in_valid  input  1  in_mask valid.
- in_ready  output  1  block can accept a mask.
- in_mask  input  LANES  mask to scan.
- out_valid  output  1  out_lane valid.
- out_ready  input  1  consumer accepts out_lane.
- out_lane  output  IDX_W  index of lowest remaining set lane.
- out_last  output  1  out_lane is the final set lane of this mask.
- done_valid  output  1  one-cycle pulse, scan finished.
- done_count  output  IDX_W+1  number of set lanes, 0..64.
- done_thermo  output  1  mask was non-zero and of form 2**(k+1)-1.
- done_len  output  IDX_W  k when done_thermo=1, else 0.

Behaviour:
- Reset (rst low, async): state IDLE, pending mask 0, count 0, thermo/len registers 0. Outputs: in_ready=1, out_valid=0, out_lane=0, out_last=0, done_valid=0, done_count=0, done_thermo=0, done_len=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register pending=in_mask, count=0.
  - Register thermo = (in_mask!=0) && ((in_mask & (in_mask+1))==0), LANES-bit add, carry discarded, so all-ones gives thermo=1.
  - Register len = popcount(in_mask)-1 if thermo, else 0.
  - Next state is SCAN if in_mask!=0, else DONE.
- SCAN:
  - in_ready=0, out_valid=1.
  - out_lane = priority-encoded lowest set bit of pending, combinational from the register.
  - out_last = ((pending & (pending-1))==0).
  - On out_ready: clear the lowest set bit (pending &= pending-1) and count+=1. If out_last, go to DONE.
  - out_valid=1 with out_ready=0: out_lane and out_last held stable.
- DONE:
  - done_valid=1 for exactly one cycle; done_count/done_thermo/done_len driven from registers.
  - in_ready=0; next state IDLE.
  - done_count/thermo/len hold their value until the next DONE, and are only meaningful while done_valid=1.
- Latency: mask accepted at edge N gives first out_valid in cycle N+1. Non-empty mask with popcount P and out_ready held 1: done_valid in cycle N+1+P. Empty mask: done_valid in cycle N+1 and no out_valid.
- Throughput: one lane per cycle. IDLE and DONE each cost one bubble cycle between masks.
- flush:
  - Highest priority, in any state: next state IDLE, pending=0, no done_valid pulse.
  - If flush is asserted together with in_valid in IDLE, the mask is dropped.
  - A lane handshake in the same cycle as flush is still considered consumed by the consumer.
- Boundaries:
  - Bit 63 alone: single output with out_lane=63 and out_last=1.
  - All-ones mask: count reaches 64; the count register is IDX_W+1 bits, so there is no overflow.
  - out_lane is strictly increasing within one mask.

Test Plan:
- in_mask=64'h0000_0000_0000_000f, out_ready=1 -> out_lane 0,1,2,3 on consecutive cycles, out_last only with lane 3; done_valid next cycle, done_count=4, done_thermo=1, done_len=3.
- in_mask=64'h8000_0000_0000_0001, out_ready toggling 1,0,0,1 -> lane 0, then lane 63 held stable across the stall, out_last=1 with 63; done_count=2, done_thermo=0, done_len=0.
- in_mask=0 -> no out_valid; done_valid one cycle after accept, done_count=0, done_thermo=0.
- in_mask=64'hffff_ffff_ffff_ffff, out_ready=1 -> 64 lanes 0..63 in order; done_count=64, done_thermo=1, done_len=63; done_valid exactly 65 cycles after accept.
- in_mask=64'h00f0, flush asserted after the second lane handshake -> returns to IDLE, in_ready=1 next cycle, no done_valid; a following mask 64'h1 gives lane 0 and done_count=1.
- rst driven low mid-SCAN (async, between edges) -> out_valid, done_valid, out_lane and done_count=0 immediately; in_ready=1 while rst held low.

Source files
------------

// File: rtl/exec_mask_scan.sv
// exec_mask_scan: walks a LANES-bit exec mask and emits the index of each set
// lane, lowest first, one per out_valid/out_ready handshake. On completion it
// pulses done_valid with the active-lane count and whether the mask was a
// contiguous thermometer mask (bits 0..k set, reported as done_len = k).
//
// Ports:
//   clk, rst (async active-low), flush (sync abort of the mask in flight)
//   in_valid / in_ready / in_mask           : mask input handshake
//   out_valid / out_ready / out_lane / out_last : per-lane output handshake
//   done_valid / done_count / done_thermo / done_len : scan summary pulse
module exec_mask_scan #(
  parameter int unsigned LANES = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES-1:0]   in_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_lane,
  output logic               out_last,
  output logic               done_valid,
  output logic [IDX_W:0]     done_count,
  output logic               done_thermo,
  output logic [IDX_W-1:0]   done_len
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LANES-1:0]   pending_q;
  logic [IDX_W:0]     count_q;
  logic               thermo_q;
  logic [IDX_W-1:0]   len_q;

  logic [IDX_W-1:0]   low_idx;
  logic               low_found;
  logic [LANES-1:0]   pending_clr;
  logic               is_last;
  logic [LANES-1:0]   mask_inc;
  logic               in_thermo;
  logic [IDX_W-1:0]   in_hi_idx;
  logic [IDX_W-1:0]   in_len;
  logic               lane_hs;

  // Lowest set bit of the pending mask.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!low_found && pending_q[i]) begin
        low_idx   = IDX_W'(i);
        low_found = 1'b1;
      end
    end
  end

  // Highest set bit of the incoming mask. For a thermometer mask this equals
  // popcount-1, so it stands in for the popcount without a 7-bit adder tree.
  always_comb begin
    in_hi_idx = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_mask[i]) begin
        in_hi_idx = IDX_W'(i);
      end
    end
  end

  assign pending_clr = pending_q & (pending_q - LANES'(1));
  assign is_last     = (pending_clr == '0);
  // Carry out of the add is discarded, so all-ones is treated as thermometer.
  assign mask_inc    = in_mask + LANES'(1);
  assign in_thermo   = (in_mask != '0) && ((in_mask & mask_inc) == '0);
  assign in_len      = in_thermo ? in_hi_idx : '0;
  assign lane_hs     = (state_q == SCAN) && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (in_mask != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (out_ready && is_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      thermo_q  <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        pending_q <= '0;
      end else if (state_q == IDLE && in_valid) begin
        pending_q <= in_mask;
        count_q   <= '0;
        thermo_q  <= in_thermo;
        len_q     <= in_len;
      end else if (lane_hs) begin
        pending_q <= pending_clr;
        count_q   <= count_q + (IDX_W+1)'(1);
      end
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == SCAN);
  assign out_lane    = low_idx;
  assign out_last    = (state_q == SCAN) && is_last;
  assign done_valid  = (state_q == DONE);
  assign done_count  = count_q;
  assign done_thermo = thermo_q;
  assign done_len    = len_q;

endmodule

// File: tb/tb_exec_mask_scan.sv
module tb_exec_mask_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_lane;
  logic        out_last;
  logic        done_valid;
  logic [6:0]  done_count;
  logic        done_thermo;
  logic [5:0]  done_len;

  int checks = 0;
  int errors = 0;

  exec_mask_scan #(.LANES(64), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane(out_lane), .out_last(out_last),
    .done_valid(done_valid), .done_count(done_count),
    .done_thermo(done_thermo), .done_len(done_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] m);
    check("accept_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_mask  = m;
    tick();
    in_valid = 1'b0;
    in_mask  = '0;
  endtask

  task automatic check_done(input string tag, input logic [6:0] cnt,
                            input logic th, input logic [5:0] len);
    check({tag, "_done_valid"}, 64'(done_valid), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    check({tag, "_done_count"}, 64'(done_count), 64'(cnt));
    check({tag, "_done_thermo"}, 64'(done_thermo), 64'(th));
    check({tag, "_done_len"}, 64'(done_len), 64'(len));
    tick();
    check({tag, "_done_pulse_end"}, 64'(done_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_lane", 64'(out_lane), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_done_count", 64'(done_count), 64'd0);
    check("rst_done_thermo", 64'(done_thermo), 64'd0);
    check("rst_done_len", 64'(done_len), 64'd0);
    #10 rst = 1'b1;
    tick();

    // Mask 0xf, out_ready held high
    out_ready = 1'b1;
    accept(64'h0000_0000_0000_000f);
    for (int i = 0; i < 4; i++) begin
      check("f_out_valid", 64'(out_valid), 64'd1);
      check("f_out_lane", 64'(out_lane), 64'(i));
      check("f_out_last", 64'(out_last), 64'(i == 3));
      check("f_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    check_done("f", 7'd4, 1'b1, 6'd3);

    // Mask with bits 0 and 63, stalled on the second lane
    accept(64'h8000_0000_0000_0001);
    check("b_lane0", 64'(out_lane), 64'd0);
    check("b_last0", 64'(out_last), 64'd0);
    tick();
    out_ready = 1'b0;
    check("b_lane63_a", 64'(out_lane), 64'd63);
    check("b_last63_a", 64'(out_last), 64'd1);
    tick();
    check("b_valid_stall", 64'(out_valid), 64'd1);
    check("b_lane63_b", 64'(out_lane), 64'd63);
    check("b_last63_b", 64'(out_last), 64'd1);
    tick();
    out_ready = 1'b1;
    check("b_lane63_c", 64'(out_lane), 64'd63);
    check("b_done_early", 64'(done_valid), 64'd0);
    tick();
    check_done("b", 7'd2, 1'b0, 6'd0);

    // Empty mask
    accept(64'h0);
    check_done("z", 7'd0, 1'b0, 6'd0);

    // All ones: done exactly 65 cycles after accept
    accept(64'hffff_ffff_ffff_ffff);
    for (int i = 0; i < 64; i++) begin
      check("a_out_valid", 64'(out_valid), 64'd1);
      check("a_out_lane", 64'(out_lane), 64'(i));
      check("a_out_last", 64'(out_last), 64'(i == 63));
      check("a_no_done", 64'(done_valid), 64'd0);
      tick();
    end
    check_done("a", 7'd64, 1'b1, 6'd63);

    // Flush after the second lane handshake
    accept(64'h0000_0000_0000_00f0);
    check("fl_lane4", 64'(out_lane), 64'd4);
    tick();
    check("fl_lane5", 64'(out_lane), 64'd5);
    tick();
    check("fl_lane6", 64'(out_lane), 64'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_done_valid", 64'(done_valid), 64'd0);
    tick();
    check("fl_done_valid2", 64'(done_valid), 64'd0);
    accept(64'h1);
    check("fl_next_lane", 64'(out_lane), 64'd0);
    check("fl_next_last", 64'(out_last), 64'd1);
    tick();
    check_done("fl1", 7'd1, 1'b1, 6'd0);

    // Flush together with in_valid in IDLE drops the mask
    in_valid = 1'b1;
    in_mask  = 64'h3;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("drop_in_ready", 64'(in_ready), 64'd1);
    check("drop_out_valid", 64'(out_valid), 64'd0);
    check("drop_done_valid", 64'(done_valid), 64'd0);

    // Async reset in the middle of a scan
    accept(64'hffff_ffff_ffff_ffff);
    tick();
    tick();
    check("r_pre_lane", 64'(out_lane), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("r_out_valid", 64'(out_valid), 64'd0);
    check("r_done_valid", 64'(done_valid), 64'd0);
    check("r_out_lane", 64'(out_lane), 64'd0);
    check("r_done_count", 64'(done_count), 64'd0);
    check("r_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("r_in_ready_held", 64'(in_ready), 64'd1);
    check("r_out_valid_held", 64'(out_valid), 64'd0);
    #2 rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
